axi_aw_rr_allocator: RTL

- Per-initiator-port AW/W allocator. Shares one slave-side AW channel among N_TARG_PORT requesting target ports using round-robin arbitration.
- Records each granted requester in an order FIFO, then routes that requester's W beats to the slave in AW acceptance order.
- Sits downstream of the per-target AW address decoders, one instance per initiator port.
- Payload muxing is external, driven by the one-hot select outputs.

---
 rtl/axi_node_pkg.sv | 14 +
 rtl/axi_aw_order_fifo.sv | 52 +++++
 rtl/axi_aw_rr_allocator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/axi_node_pkg.sv
// Shared types and helpers for the AXI node allocators.
package axi_node_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } aw_alloc_state_t;

    // Callers size-cast the result down to their own port count (at most 32).
    function automatic logic [31:0] onehot_from_idx(input logic [4:0] idx);
        onehot_from_idx = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/axi_aw_order_fifo.sv
// Order FIFO of granted requester indices; the head steers W routing.
module axi_aw_order_fifo #(
    parameter  int IDX_W = 3,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [IDX_W-1:0] i_push_idx,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [IDX_W-1:0] o_head
);

    logic [IDX_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    // Full is judged on the registered count, so a same-cycle pop never makes room.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_idx;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axi_aw_rr_allocator.sv
// Round-robin AW allocator for one initiator port, with W routed in AW acceptance order.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid never depends on ready.
module axi_aw_rr_allocator
    import axi_node_pkg::*;
#(
    parameter  int N_TARG_PORT = 8,
    parameter  int FIFO_DEPTH  = 4,
    localparam int IDX_W       = $clog2(N_TARG_PORT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_TARG_PORT-1:0] awvalid_i,
    output logic [N_TARG_PORT-1:0] awready_o,
    output logic                   awvalid_o,
    input  logic                   awready_i,
    output logic [N_TARG_PORT-1:0] aw_sel_o,
    input  logic [N_TARG_PORT-1:0] wvalid_i,
    input  logic [N_TARG_PORT-1:0] wlast_i,
    output logic [N_TARG_PORT-1:0] wready_o,
    output logic                   wvalid_o,
    output logic                   wlast_o,
    input  logic                   wready_i,
    output logic [N_TARG_PORT-1:0] w_sel_o,
    output logic                   fifo_full_o,
    output logic                   dbg_state_o
);

    aw_alloc_state_t  r_state, w_next_state;
    logic [IDX_W-1:0] r_ptr, w_next_ptr;
    logic [IDX_W-1:0] r_lock, w_next_lock;
    logic [IDX_W-1:0] w_win;
    logic             w_found;
    logic             w_push;
    logic [IDX_W-1:0] w_push_idx;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [IDX_W-1:0] w_head;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] k);
        rr_next = (k == IDX_W'(N_TARG_PORT - 1)) ? '0 : k + 1'b1;
    endfunction

    // First valid requester at or above the pointer, wrapping.
    always_comb begin
        int j;
        logic [IDX_W-1:0] w_cand;
        j       = 0;
        w_cand  = '0;
        w_win   = r_ptr;
        w_found = 1'b0;
        for (int i = 0; i < N_TARG_PORT; i++) begin
            j = int'(r_ptr) + i;
            if (j >= N_TARG_PORT) j = j - N_TARG_PORT;
            w_cand = IDX_W'(j);
            if (!w_found && awvalid_i[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        w_next_lock  = r_lock;
        w_push       = 1'b0;
        w_push_idx   = '0;
        awvalid_o    = 1'b0;
        aw_sel_o     = '0;
        awready_o    = '0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (w_found && !w_full) begin
                        awvalid_o = 1'b1;
                        aw_sel_o  = N_TARG_PORT'(onehot_from_idx(5'(w_win)));
                        awready_o = aw_sel_o & {N_TARG_PORT{awready_i}};
                        if (awready_i) begin
                            w_push     = 1'b1;
                            w_push_idx = w_win;
                            w_next_ptr = rr_next(w_win);
                        end else begin
                            w_next_lock  = w_win;
                            w_next_state = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    // Grant is held even if the requester drops valid.
                    awvalid_o = 1'b1;
                    aw_sel_o  = N_TARG_PORT'(onehot_from_idx(5'(r_lock)));
                    awready_o = aw_sel_o & {N_TARG_PORT{awready_i}};
                    if (awready_i) begin
                        w_push       = 1'b1;
                        w_push_idx   = r_lock;
                        w_next_ptr   = rr_next(r_lock);
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_lock  <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
            r_lock  <= w_next_lock;
        end
    end

    always_comb begin
        wvalid_o = 1'b0;
        wlast_o  = 1'b0;
        wready_o = '0;
        w_sel_o  = '0;
        if (!w_empty) begin
            w_sel_o  = N_TARG_PORT'(onehot_from_idx(5'(w_head)));
            wvalid_o = wvalid_i[w_head];
            wlast_o  = wlast_i[w_head];
            wready_o = w_sel_o & {N_TARG_PORT{wready_i}};
        end
    end

    assign w_pop       = wvalid_o & wready_i & wlast_o;
    assign fifo_full_o = w_full;
    assign dbg_state_o = (r_state == LOCKED);

    axi_aw_order_fifo #(
        .IDX_W (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_order_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_idx (w_push_idx),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (w_head)
    );

endmodule
